fetch_align: RTL and testbench

Instruction fetch and realignment stage directly upstream of the instruction decoder.
- Issues word-aligned 32-bit fetches to instruction memory and buffers the returned halfwords.
- Presents one instruction per valid/ready handshake, with its PC, to the decoder.
- Reassembles 32-bit instructions that straddle a word boundary and handles compressed (16-bit) parcels and control-flow redirects.

---
 rtl/fetch_align.sv | 152 +++++++++++++++
 tb/tb_fetch_align.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_align.sv
// Fetch/realign stage: word fetches into a 4-halfword buffer, one instruction per handshake.
// Optional compressed-parcel support is enabled by defining FETCH_RVC_EN.
module fetch_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_req_valid,
  output logic [31:0] o_req_addr,
  input  logic        i_req_ready,
  input  logic        i_rsp_valid,
  input  logic [31:0] i_rsp_data,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_compressed,
  input  logic        i_inst_ready
);

`ifdef FETCH_RVC_EN
  localparam logic        RVC_EN  = 1'b1;
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFF;
`else
  localparam logic        RVC_EN  = 1'b0;
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFD;
`endif

  localparam logic [31:0] RST_PC = RESET_PC & PC_MASK;

  logic [15:0] hbuf_q [4];
  logic [15:0] hbuf_d [4];
  logic [15:0] shifted [4];
  logic [2:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        outstanding_q, outstanding_d;
  logic        drop_q, drop_d;
  logic        skip_lo_q, skip_lo_d;

  logic        head_comp;
  logic        inst_valid;
  logic        req_fire;
  logic        inst_fire;
  logic [2:0]  pop_n;
  logic [2:0]  push_n;
  logic [2:0]  base;
  logic [31:0] redir_pc;

  // Handshakes: a transfer happens in a cycle where valid && ready; valid never depends on ready.
  assign head_comp  = RVC_EN && (hbuf_q[0][1:0] != 2'b11);
  assign inst_valid = !i_rst && !i_redirect &&
                      (head_comp ? (count_q >= 3'd1) : (count_q >= 3'd2));

  assign o_inst_valid = inst_valid;
  assign o_inst       = head_comp ? {16'h0000, hbuf_q[0]} : {hbuf_q[1], hbuf_q[0]};
  assign o_inst_pc    = head_pc_q;
  assign o_compressed = head_comp;

  // At most one request in flight, and only when two more halfwords are guaranteed to fit.
  assign o_req_valid = !i_rst && !i_redirect && !outstanding_q && (count_q <= 3'd2);
  assign o_req_addr  = {fetch_pc_q[31:2], 2'b00};

  assign req_fire  = o_req_valid && i_req_ready;
  assign inst_fire = inst_valid && i_inst_ready;
  assign redir_pc  = i_redirect_pc & PC_MASK;

  always_comb begin
    pop_n  = 3'd0;
    push_n = 3'd0;
    if (inst_fire) begin
      pop_n = head_comp ? 3'd1 : 3'd2;
    end
    if (i_rsp_valid && !drop_q) begin
      push_n = skip_lo_q ? 3'd1 : 3'd2;
    end
    base = count_q - pop_n;

    case (pop_n)
      3'd1:    shifted = '{hbuf_q[1], hbuf_q[2], hbuf_q[3], 16'h0000};
      3'd2:    shifted = '{hbuf_q[2], hbuf_q[3], 16'h0000, 16'h0000};
      default: shifted = hbuf_q;
    endcase

    // Newly returned halfwords land directly behind whatever survives the pop.
    for (int i = 0; i < 4; i++) begin
      hbuf_d[i] = shifted[i];
      if (push_n == 3'd2) begin
        if (3'(i) == base) begin
          hbuf_d[i] = i_rsp_data[15:0];
        end else if (3'(i) == base + 3'd1) begin
          hbuf_d[i] = i_rsp_data[31:16];
        end
      end else if (push_n == 3'd1 && 3'(i) == base) begin
        hbuf_d[i] = i_rsp_data[31:16];
      end
    end

    count_d       = count_q + push_n - pop_n;
    head_pc_d     = head_pc_q + {28'h0, pop_n, 1'b0};
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    skip_lo_d     = skip_lo_q;

    if (i_rsp_valid) begin
      outstanding_d = 1'b0;
      if (drop_q) begin
        drop_d = 1'b0;
      end else begin
        skip_lo_d = 1'b0;
      end
    end
    if (req_fire) begin
      outstanding_d = 1'b1;
      fetch_pc_d    = o_req_addr + 32'd4;
    end

    // A redirect discards the buffer; a request still in flight is remembered as stale.
    if (i_redirect) begin
      hbuf_d        = hbuf_q;
      count_d       = 3'd0;
      head_pc_d     = redir_pc;
      fetch_pc_d    = redir_pc;
      skip_lo_d     = RVC_EN && redir_pc[1];
      drop_d        = outstanding_q && !i_rsp_valid;
      outstanding_d = outstanding_q && !i_rsp_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hbuf_q        <= '{default: 16'h0000};
      count_q       <= 3'd0;
      head_pc_q     <= RST_PC;
      fetch_pc_q    <= RST_PC;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      skip_lo_q     <= RVC_EN && RST_PC[1];
    end else begin
      hbuf_q        <= hbuf_d;
      count_q       <= count_d;
      head_pc_q     <= head_pc_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      skip_lo_q     <= skip_lo_d;
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: memory responder, instruction-stream reference model, directed and random phases.
module tb_fetch_align;

`ifdef FETCH_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_req_valid;
  logic [31:0] o_req_addr;
  logic        i_req_ready;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_compressed;
  logic        i_inst_ready;

  fetch_align #(.RESET_PC(RESET_PC)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_req_valid(o_req_valid), .o_req_addr(o_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .o_compressed(o_compressed), .i_inst_ready(i_inst_ready)
  );

  // Clock / timeout
  always #5 i_clk = ~i_clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;

  // Memory image and responder state
  logic [31:0] mem [64];
  logic        pend_valid;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          lat;

  // Reference model: expected instruction stream walked from the architectural PC
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];
  logic        exp_c_q[$];
  logic [31:0] gen_pc;
  logic [31:0] exp_addr;
  logic        prev_stall;
  logic        req_fired;
  logic        valid_seen;
  int          n_req;
  int          n_cons;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] hw(input logic [31:0] a);
    return a[1] ? mem[a[7:2]][31:16] : mem[a[7:2]][15:0];
  endfunction

  task automatic refill();
    logic [15:0] h;
    while (exp_q.size() < 4) begin
      h = hw(gen_pc);
      if (RVC && h[1:0] != 2'b11) begin
        exp_q.push_back({16'h0000, h});
        exp_pc_q.push_back(gen_pc);
        exp_c_q.push_back(1'b1);
        gen_pc = gen_pc + 32'd2;
      end else begin
        exp_q.push_back({hw(gen_pc + 32'd2), h});
        exp_pc_q.push_back(gen_pc);
        exp_c_q.push_back(1'b0);
        gen_pc = gen_pc + 32'd4;
      end
    end
  endtask

  task automatic model_restart(input logic [31:0] pc);
    logic [31:0] p;
    p = RVC ? pc : (pc & 32'hFFFF_FFFD);
    exp_q.delete();
    exp_pc_q.delete();
    exp_c_q.delete();
    gen_pc     = p;
    exp_addr   = {p[31:2], 2'b00};
    prev_stall = 1'b0;
    refill();
  endtask

  // Sampled at the falling edge: checks outputs and predicts the coming rising edge.
  task automatic check_cycle();
    req_fired  = 1'b0;
    valid_seen = o_inst_valid;
    if (i_rst) begin
      chk("rst_req_valid", 32'(o_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(o_inst_valid), 32'd0);
      prev_stall = 1'b0;
    end else if (i_redirect) begin
      chk("redir_inst_valid", 32'(o_inst_valid), 32'd0);
      chk("redir_req_valid", 32'(o_req_valid), 32'd0);
      model_restart(i_redirect_pc);
    end else begin
      if (prev_stall) chk("hold_valid", 32'(o_inst_valid), 32'd1);
      if (o_inst_valid) begin
        chk("inst_pc", o_inst_pc, exp_pc_q[0]);
        chk("inst", o_inst, exp_q[0]);
        chk("compressed", 32'(o_compressed), 32'(exp_c_q[0]));
        if (i_inst_ready) begin
          void'(exp_q.pop_front());
          void'(exp_pc_q.pop_front());
          void'(exp_c_q.pop_front());
          refill();
          n_cons++;
        end
      end
      prev_stall = o_inst_valid && !i_inst_ready;
      if (o_req_valid && i_req_ready) begin
        chk("req_addr", o_req_addr, exp_addr);
        exp_addr   = exp_addr + 32'd4;
        pend_valid = 1'b1;
        pend_addr  = o_req_addr;
        pend_cnt   = lat;
        req_fired  = 1'b1;
        n_req++;
      end
    end
  endtask

  task automatic drive_rsp();
    i_rsp_valid = 1'b0;
    i_rsp_data  = $urandom;
    if (pend_valid) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        i_rsp_valid = 1'b1;
        i_rsp_data  = mem[pend_addr[7:2]];
        pend_valid  = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    check_cycle();
    @(posedge i_clk);
    #1;
    i_redirect = 1'b0;
    if (i_rst) pend_valid = 1'b0;
    drive_rsp();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    i_redirect    = 1'b1;
    i_redirect_pc = pc;
    step();
  endtask

  task automatic fill_mem(input logic rnd);
    for (int i = 0; i < 64; i++) mem[i] = rnd ? $urandom : 32'h0000_0013;
  endtask

  int first;
  int n_req0;

  initial begin
    i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = 32'h0;
    i_req_ready = 1'b1; i_rsp_valid = 1'b0; i_rsp_data = 32'h0; i_inst_ready = 1'b0;
    pend_valid = 1'b0; pend_addr = 32'h0; pend_cnt = 0; lat = 1;
    n_req = 0; n_cons = 0; prev_stall = 1'b0;
    fill_mem(1'b0);
    repeat (3) step();
    i_rst = 1'b0;
    model_restart(RESET_PC);

    // Latency from an empty buffer: request R, response R+1, instruction R+2
    step();
    chk("lat_req_r", 32'(req_fired), 32'd1);
    chk("lat_valid_r", 32'(valid_seen), 32'd0);
    step();
    chk("lat_valid_r1", 32'(valid_seen), 32'd0);
    step();
    chk("lat_valid_r2", 32'(valid_seen), 32'd1);
    i_inst_ready = 1'b1;
    repeat (20) step();

    // Two compressed parcels then a 32-bit nop
    mem[0] = 32'h0001_0001; mem[1] = 32'h0000_0013;
    do_redirect(32'h0);
    repeat (12) step();

    // Straddling 32-bit instruction
    mem[0] = 32'h0013_0001; mem[1] = 32'h0000_0000;
    do_redirect(32'h0);
    repeat (12) step();

    // Redirect to a halfword-aligned target
    mem[0] = 32'h0093_0001; mem[1] = 32'h0000_0000;
    do_redirect(32'h102);
    repeat (12) step();

    // Redirect with a request in flight; its response arrives two cycles later
    fill_mem(1'b0);
    lat = 3;
    first = 0;
    for (int k = 0; k < 20 && !req_fired; k++) step();
    chk("or_req_seen", 32'(req_fired), 32'd1);
    do_redirect(32'h40);
    for (int k = 1; k <= 6; k++) begin
      step();
      if (req_fired && first == 0) first = k;
    end
    chk("or_restart_cycle", 32'(first), 32'd3);
    lat = 1;
    repeat (10) step();

    // Back-pressure: buffer fills with two words, then fetching stops
    do_redirect(32'h200);
    i_inst_ready = 1'b0;
    n_req0 = n_req;
    repeat (12) step();
    chk("hold_req_count", 32'(n_req - n_req0), 32'd2);
    chk("hold_req_valid", 32'(o_req_valid), 32'd0);
    chk("hold_inst_valid", 32'(o_inst_valid), 32'd1);
    i_inst_ready = 1'b1;
    step();
    i_inst_ready = 1'b0;
    step();
    chk("resume_req", 32'(req_fired), 32'd1);
    i_inst_ready = 1'b1;
    repeat (8) step();

    // PC wrap-around
    fill_mem(1'b1);
    do_redirect(32'hFFFF_FFF8);
    repeat (20) step();
    do_redirect(32'hFFFF_FFFA);
    repeat (20) step();

    // Random ready patterns, latencies, memory images and redirects
    for (int n = 0; n < 1500; n++) begin
      i_inst_ready = ($urandom_range(0, 3) != 0);
      i_req_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 60) == 0) begin
        lat = $urandom_range(1, 3);
        fill_mem(1'b1);
        do_redirect($urandom & 32'hFFFF_FFFE);
      end else begin
        step();
      end
    end
    chk("progress", 32'(n_cons > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
